// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer, the cpum core and the assembler scripts.
//   - opcode constants for the 4-bit opcode field ins[19:16]
//   - the NOP instruction word
//   - the sequencer state encoding
package seq_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_JS   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [19:0] NOP = 20'h0;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    HALTED
  } seq_state_e;

endpackage

// File: rtl/ins_sequencer.sv
// Instruction sequencer for cpum. Fetches instructions from a synchronous-read memory,
// resolves JMP/JZ/JS/HALT locally and hands every other instruction to cpum on `ins`
// for exactly one cycle.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           pulse, starts execution from IDLE or HALTED
//   imem_en/addr    registered instruction-memory read request
//   imem_rdata      read data, valid the cycle after imem_en
//   zf, sf          cpum flags, sampled in DECODE
//   ins             registered instruction to cpum, zero outside EXEC
//   pc              program counter
//   busy, halted    status
//   retired         saturating count of executed datapath and branch instructions
module ins_sequencer
  import seq_pkg::*;
#(
  parameter int unsigned AW = 8,
  parameter int unsigned IW = 20,
  parameter int unsigned CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          imem_en,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          zf,
  input  logic          sf,
  output logic [IW-1:0] ins,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          halted,
  output logic [CW-1:0] retired
);

  seq_state_e    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [IW-1:0] ir_q, ir_d;
  logic [IW-1:0] ins_q, ins_d;
  logic          imem_en_q, imem_en_d;
  logic [AW-1:0] imem_addr_q, imem_addr_d;
  logic [CW-1:0] retired_q, retired_d;
  logic          retire;

  logic [3:0]    opcode;
  logic [AW-1:0] target;
  logic [AW-1:0] pc_inc;

  assign opcode = imem_rdata[IW-1 -: 4];
  assign target = imem_rdata[AW-1:0];
  assign pc_inc = pc_q + AW'(1);  // wraps silently

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    retire  = 1'b0;
    unique case (state_q)
      IDLE, HALTED: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = DECODE;
      DECODE: begin
        ir_d = imem_rdata;
        case (opcode)
          OP_HALT: state_d = HALTED;
          OP_JMP: begin
            pc_d    = target;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_JZ: begin
            pc_d    = zf ? target : pc_inc;
            retire  = 1'b1;
            state_d = FETCH;
          end
          OP_JS: begin
            pc_d    = sf ? target : pc_inc;
            retire  = 1'b1;
            state_d = FETCH;
          end
          default: state_d = EXEC;
        endcase
      end
      EXEC: begin
        pc_d    = pc_inc;
        retire  = 1'b1;
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    ins_d       = IW'(NOP);
    imem_en_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    retired_d   = retired_q;
    if (state_d == EXEC) begin
      ins_d = ir_d;
    end
    if (state_d == FETCH) begin
      imem_en_d   = 1'b1;
      imem_addr_d = pc_d;
    end
    if (retire && (retired_q != '1)) begin
      retired_d = retired_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= '0;
      ins_q       <= '0;
      imem_en_q   <= 1'b0;
      imem_addr_q <= '0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      ins_q       <= ins_d;
      imem_en_q   <= imem_en_d;
      imem_addr_q <= imem_addr_d;
      retired_q   <= retired_d;
    end
  end

  assign ins       = ins_q;
  assign pc        = pc_q;
  assign imem_en   = imem_en_q;
  assign imem_addr = imem_addr_q;
  assign retired   = retired_q;
  assign busy      = (state_q == FETCH) || (state_q == DECODE) || (state_q == EXEC);
  assign halted    = (state_q == HALTED);

endmodule

// File: tb/tb_ins_sequencer.sv
// Bench for ins_sequencer: instruction-memory models, a fetch-address and issued-instruction
// scoreboard, and a narrow-counter instance for retired-count saturation.
module tb_ins_sequencer;
  import seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, start_s, zf, sf;
  logic        imem_en, busy, halted;
  logic [7:0]  imem_addr, pc;
  logic [19:0] imem_rdata, ins;
  logic [15:0] retired;

  logic        imem_en_s, busy_s, halted_s;
  logic [7:0]  imem_addr_s, pc_s;
  logic [19:0] imem_rdata_s, ins_s;
  logic [1:0]  retired_s;

  logic [19:0] mem   [256];
  logic [19:0] mem_s [256];

  logic [19:0] exp_ins[$];
  logic [7:0]  exp_fetch[$];

  int n_checks = 0;
  int n_pass   = 0;

  ins_sequencer #(.AW(8), .IW(20), .CW(16)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .imem_en   (imem_en),
    .imem_addr (imem_addr),
    .imem_rdata(imem_rdata),
    .zf        (zf),
    .sf        (sf),
    .ins       (ins),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .retired   (retired)
  );

  // Two-bit counter so saturation is reached in a handful of instructions.
  ins_sequencer #(.AW(8), .IW(20), .CW(2)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_s),
    .imem_en   (imem_en_s),
    .imem_addr (imem_addr_s),
    .imem_rdata(imem_rdata_s),
    .zf        (zf),
    .sf        (sf),
    .ins       (ins_s),
    .pc        (pc_s),
    .busy      (busy_s),
    .halted    (halted_s),
    .retired   (retired_s)
  );

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];
  always @(posedge clk) if (imem_en_s) imem_rdata_s <= mem_s[imem_addr_s];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard: compare every fetch and every issued instruction against the queued plan.
  logic [19:0] prev_ins = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ins = '0;
    end else begin
      if (ins != '0) begin
        if (prev_ins != '0) check("ins_one_cycle", {12'h0, ins}, 32'h0);
        if (exp_ins.size() == 0) check("ins_unexpected", {12'h0, ins}, 32'h0);
        else check("ins", {12'h0, ins}, {12'h0, exp_ins.pop_front()});
      end
      prev_ins = ins;
      if (imem_en) begin
        if (exp_fetch.size() == 0) check("fetch_unexpected", {31'h0, imem_en}, 32'h0);
        else check("fetch_addr", {24'h0, imem_addr}, {24'h0, exp_fetch.pop_front()});
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      mem[i]   = NOP;
      mem_s[i] = NOP;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_ins.delete();
    exp_fetch.delete();
    clear_mem();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n;
    n = 0;
    while (!halted && n < 60) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'h0, halted}, 32'h1);
  endtask

  task automatic check_drained(input string tag);
    check({tag, "_ins_left"}, exp_ins.size(), 32'h0);
    check({tag, "_fetch_left"}, exp_fetch.size(), 32'h0);
  endtask

  initial begin
    int k;
    rst_n   = 1'b0;
    start   = 1'b0;
    start_s = 1'b0;
    zf      = 1'b0;
    sf      = 1'b0;
    clear_mem();
    do_reset();

    // Reset state
    check("rst_pc", {24'h0, pc}, 32'h0);
    check("rst_ins", {12'h0, ins}, 32'h0);
    check("rst_imem_en", {31'h0, imem_en}, 32'h0);
    check("rst_imem_addr", {24'h0, imem_addr}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_retired", {16'h0, retired}, 32'h0);

    // Datapath instruction then HALT; ins appears in the third cycle after start
    mem[0] = 20'h1_0005;
    mem[1] = 20'hF_0000;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h01);
    exp_ins.push_back(20'h1_0005);
    do_start();
    check("t1_busy", {31'h0, busy}, 32'h1);
    k = 0;
    while (ins == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("t1_ins_latency", k, 32'd3);
    wait_halt("t1_halt");
    check("t1_pc", {24'h0, pc}, 32'h1);
    check("t1_retired", {16'h0, retired}, 32'h1);
    check("t1_busy_off", {31'h0, busy}, 32'h0);
    check_drained("t1");

    // JMP, with a start pulse while busy that must be ignored
    do_reset();
    mem[0]  = 20'hC_0010;
    mem[16] = 20'hF_0000;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h10);
    do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_halt("jmp_halt");
    check("jmp_pc", {24'h0, pc}, 32'h10);
    check("jmp_retired", {16'h0, retired}, 32'h1);
    check_drained("jmp");

    // JZ taken
    do_reset();
    zf = 1'b1;
    mem[0]     = 20'hD_0040;
    mem[8'h40] = 20'hF_0000;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h40);
    do_start();
    wait_halt("jz_t_halt");
    check("jz_t_pc", {24'h0, pc}, 32'h40);
    check("jz_t_retired", {16'h0, retired}, 32'h1);
    check_drained("jz_t");

    // JZ not taken
    do_reset();
    zf = 1'b0;
    mem[0]     = 20'hD_0040;
    mem[1]     = 20'hF_0000;
    mem[8'h40] = 20'hF_0000;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h01);
    do_start();
    wait_halt("jz_n_halt");
    check("jz_n_pc", {24'h0, pc}, 32'h1);
    check_drained("jz_n");

    // JS taken
    do_reset();
    sf = 1'b1;
    mem[0]     = 20'hE_0020;
    mem[1]     = 20'hF_0000;
    mem[8'h20] = 20'hF_0000;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h20);
    do_start();
    wait_halt("js_t_halt");
    check("js_t_pc", {24'h0, pc}, 32'h20);
    check_drained("js_t");
    sf = 1'b0;

    // PC wrap: datapath at 0xFF, next fetch from 0 (rewritten to HALT once 0xFF is fetched)
    do_reset();
    mem[0]     = 20'hC_00FF;
    mem[8'hFF] = 20'h2_0077;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'hFF);
    exp_fetch.push_back(8'h00);
    exp_ins.push_back(20'h2_0077);
    do_start();
    k = 0;
    while (!(imem_en && imem_addr == 8'hFF) && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("wrap_reach_ff", {24'h0, imem_addr}, 32'hFF);
    mem[0] = 20'hF_0000;
    wait_halt("wrap_halt");
    check("wrap_pc", {24'h0, pc}, 32'h0);
    check("wrap_retired", {16'h0, retired}, 32'h2);
    check_drained("wrap");

    // Restart from HALTED, then asynchronous reset in the middle of EXEC
    mem[0] = 20'h3_0033;
    mem[1] = 20'hF_0000;
    exp_fetch.push_back(8'h00);
    exp_ins.push_back(20'h3_0033);
    do_start();
    k = 0;
    while (ins == '0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ar_exec_seen", {12'h0, ins}, 32'h3_0033);
    #1 rst_n = 1'b0;
    #1;
    check("ar_ins", {12'h0, ins}, 32'h0);
    check("ar_busy", {31'h0, busy}, 32'h0);
    check("ar_pc", {24'h0, pc}, 32'h0);
    check("ar_retired", {16'h0, retired}, 32'h0);
    check_drained("ar");
    @(negedge clk);
    rst_n = 1'b1;
    exp_fetch.push_back(8'h00);
    exp_fetch.push_back(8'h01);
    exp_ins.push_back(20'h3_0033);
    do_start();
    wait_halt("ar_restart_halt");
    check("ar_restart_pc", {24'h0, pc}, 32'h1);
    check("ar_restart_retired", {16'h0, retired}, 32'h1);
    check_drained("ar_restart");

    // Saturation on the 2-bit counter instance: five instructions leave it at all-ones
    do_reset();
    for (int i = 0; i < 5; i++) mem_s[i] = 20'h1_0001;
    mem_s[5] = 20'hF_0000;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    k = 0;
    while (!halted_s && k < 80) begin
      @(negedge clk);
      k++;
    end
    check("sat_halt", {31'h0, halted_s}, 32'h1);
    check("sat_retired", {30'h0, retired_s}, 32'h3);
    check("sat_pc", {24'h0, pc_s}, 32'h5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ins_sequencer.md
# ins_sequencer

Instruction sequencer for the 8-bit CPU core `cpum`.
- Fetches 20-bit instructions from a synchronous-read instruction memory and resolves control-flow opcodes itself, using the core's `zf`/`sf` flags.
- Presents each datapath instruction on the core's `ins` input for exactly one clock.
- Sits between the instruction ROM/RAM and `cpum`; drives `cpum.ins` directly.

## Interface
Parameters:
- `AW`, 8, instruction address width (256-word program space)
- `IW`, 20, instruction width; must match `cpum.ins`
- `CW`, 16, width of the retired-instruction counter

Ports:
- `clk`  in  1  rising-edge clock, shared with `cpum`
- `rst_n`  in  1  reset: asynchronous assert, active-low
- `start`  in  1  pulse; starts execution from IDLE or HALTED
- `imem_en`  out  1  instruction-memory read enable
- `imem_addr`  out  AW  instruction-memory read address
- `imem_rdata`  in  IW  read data, valid the cycle after `imem_en`
- `zf`  in  1  zero flag from `cpum`
- `sf`  in  1  sign flag from `cpum`
- `ins`  out  IW  instruction to `cpum`; NOP (all zero) unless issuing
- `pc`  out  AW  current program counter
- `busy`  out  1  high in FETCH/DECODE/EXEC
- `halted`  out  1  high in HALTED
- `retired`  out  CW  count of executed instructions (datapath and branch), saturating

## Operation
Opcode field is `ins[19:16]`. The sequencer consumes these opcodes; all others are forwarded to `cpum`:
- JMP = 4'hC
- JZ = 4'hD
- JS = 4'hE
- HALT = 4'hF

Branch target is `ins[AW-1:0]`.

Opcode 4'h0 with all-zero operands is NOP. `cpum` must treat it as no state change.

States:
- IDLE: wait for `start`. Then `pc`←0, go to FETCH.
- FETCH: `imem_en`=1, `imem_addr`=`pc`. Always go to DECODE.
- DECODE: capture `imem_rdata` into the instruction register `ir`, then branch on opcode:
  - HALT → HALTED; `pc` unchanged; not counted.
  - JMP → `pc`←target → FETCH.
  - JZ → `pc`←(`zf` ? target : `pc`+1) → FETCH.
  - JS → `pc`←(`sf` ? target : `pc`+1) → FETCH.
  - Any other opcode → EXEC.
- EXEC: `ins`=`ir` for this single cycle; `pc`←`pc`+1 → FETCH.
- HALTED: `start` → `pc`←0 → FETCH. Otherwise hold.

Rules:
- `retired` increments on the EXEC exit and on every branch-class DECODE exit. It saturates at all-ones.
- `pc`+1 wraps 8'hFF→8'h00 silently.
- Flags are sampled combinationally in DECODE. They reflect the most recent EXEC, which is at least 2 cycles earlier, so no hazard exists.
- `start` is ignored while `busy`.
- `start` in the same cycle that HALT is decoded is ignored; the block still enters HALTED.

## Timing
- Reset (async assert, sync-deasserted externally):
  - state=IDLE, `pc`=0, `ir`=0, `ins`=0, `imem_en`=0, `imem_addr`=0
  - `busy`=0, `halted`=0, `retired`=0
- Reset mid-instruction aborts immediately. `ins` returns to 0 in the same instant, so no partial instruction reaches `cpum`.
- Datapath instruction: 3 cycles (FETCH, DECODE, EXEC).
- Branch, taken or not: 2 cycles (FETCH, DECODE).
- `start` sampled high in IDLE at edge N → FETCH in cycle N+1 with `imem_addr`=0 → first `ins` drive in cycle N+3.
- `ins` is registered: it is non-zero only during EXEC and is zero on every other cycle. `cpum` executes it on the edge closing EXEC.
- `imem_addr` and `imem_en` are registered from the state/`pc` update.

## Structure
- Shared package `seq_pkg` holds:
  - opcode constants (`OP_NOP`, `OP_JMP`, `OP_JZ`, `OP_JS`, `OP_HALT`)
  - the `NOP` instruction constant (20'h0)
  - the state enum (IDLE, FETCH, DECODE, EXEC, HALTED)
- `cpum` and the assembler scripts also use `seq_pkg`.
- Single module. The branch-target/next-pc mux is small and stays inline; no sub-module.

## Test plan
- Reset then `start`: program {20'h1_0005, 20'hF_0000}.
  - `ins`=20'h10005 for exactly one cycle, 3 cycles after `start`.
  - Then `halted`=1, `pc`=1, `retired`=1.
- JMP: mem[0]=20'hC_0010, mem[16]=HALT.
  - `imem_addr` sequence 0, 16.
  - `ins` never non-zero; `retired`=1.
- JZ taken and not taken, with `zf` forced 1 then 0 at DECODE; mem[0]=20'hD_0040.
  - `zf`=1: next `imem_addr`=8'h40.
  - `zf`=0: next `imem_addr`=1.
- Wrap: jump to 8'hFF holding a datapath instruction.
  - After EXEC, `pc`=8'h00.
  - Next fetch is from address 0.
- Async reset during EXEC:
  - `ins`=0 and `busy`=0 immediately.
  - `pc`=0, `retired`=0.
  - A subsequent `start` restarts from address 0.
- Saturation: preload `retired` to 16'hFFFE, run 3 instructions → `retired`=16'hFFFF.
